oam_dma: RTL and testbench

- Sprite OAM DMA engine on the CPU-side bus.
- Snoops CPU writes to $4014 and halts the CPU through its ready input.
- Takes the bus and copies 256 bytes from CPU page {page,8'h00..8'hFF} into the PPU OAM data port $2004, one read/write pair per byte.
- On completion it releases the bus and CPU execution resumes.

---
 rtl/nes_bus_pkg.sv | 19 +
 rtl/oam_dma_if.sv | 25 ++
 rtl/oam_dma.sv | 96 +++++++++
 tb/tb_oam_dma.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: register addresses and the OAM DMA state encoding.
package nes_bus_pkg;

    localparam logic [15:0] PPU_REG_BASE  = 16'h2000;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;

    // One page per transfer; the 8-bit index counter fixes this at 256.
    localparam int XFER_LEN = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side bus seen by the OAM DMA engine: CPU write snoop, shared read data,
// the CPU ready line and the DMA's own bus drive.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic        cpu_write;
    logic [7:0]  cpu_d_out;
    logic [7:0]  d_in;
    logic        ready;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_write;
    logic [7:0]  dma_d_out;

    // DMA engine side.
    modport master (
        input  cpu_addr, cpu_write, cpu_d_out, d_in,
        output ready, dma_active, dma_addr, dma_write, dma_d_out
    );

    // System side: CPU snoop sources, read data source, bus mux consumer.
    modport slave (
        output cpu_addr, cpu_write, cpu_d_out, d_in,
        input  ready, dma_active, dma_addr, dma_write, dma_d_out
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a CPU write to $4014 halts the CPU, then 256 bytes from the
// selected page are copied into $2004 as read/write pairs aligned so that
// every read lands on an even cycle.
module oam_dma
    import nes_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    oam_dma_if.master  bus
);

    oam_dma_state_t state_q, state_d;
    logic [7:0]     page_q,  page_d;
    logic [7:0]     idx_q,   idx_d;
    logic [7:0]     data_q,  data_d;
    logic           parity_q;

    logic trig;
    assign trig = bus.cpu_write && (bus.cpu_addr == DMA_REG_ADDR);

    // Free-running even/odd cycle marker, restarted by reset.
    always_ff @(posedge clk) begin
        if (!reset) parity_q <= 1'b0;
        else        parity_q <= ~parity_q;
    end

    // State, page, index and latched byte registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic and bus outputs; outputs depend only on registered state.
    always_comb begin
        state_d        = state_q;
        page_d         = page_q;
        idx_d          = idx_q;
        data_d         = data_q;
        bus.ready      = 1'b0;
        bus.dma_active = 1'b0;
        bus.dma_addr   = 16'h0000;
        bus.dma_write  = 1'b0;
        bus.dma_d_out  = 8'h00;

        case (state_q)
            ST_IDLE: begin
                bus.ready = 1'b1;
                // Triggers are only honoured here, so writes during a stall are ignored.
                if (trig) begin
                    page_d  = bus.cpu_d_out;
                    idx_d   = 8'h00;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                // An odd HALT cycle means the next cycle is already even.
                state_d = parity_q ? ST_READ : ST_ALIGN;
            end
            ST_ALIGN: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                bus.dma_active = 1'b1;
                bus.dma_addr   = {page_q, idx_q};
                data_d         = bus.d_in;
                state_d        = ST_WRITE;
            end
            ST_WRITE: begin
                bus.dma_active = 1'b1;
                bus.dma_addr   = OAM_DATA_ADDR;
                bus.dma_write  = 1'b1;
                bus.dma_d_out  = data_q;
                // idx == FF ends the transfer; the counter never wraps into a 257th byte.
                if (idx_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: reset, basic copy, alignment, retrigger,
// mid-transfer reset, address decode and page boundary cases.
module tb_oam_dma;
    import nes_bus_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;

    oam_dma_if bus();

    oam_dma dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Source memory: mem[0x0200+i] = i ^ 5A, other pages shifted by page ^ 02.
    function automatic logic [7:0] memf(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
    endfunction

    always_comb bus.d_in = (bus.dma_active && !bus.dma_write) ? memf(bus.dma_addr) : 8'h00;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference even/odd cycle marker.
    logic tb_par;
    always @(posedge clk) begin
        if (!reset) tb_par <= 1'b0;
        else        tb_par <= ~tb_par;
    end

    // Bus monitor: counts reads/writes, checks order, addresses, data and read parity.
    logic [7:0]  exp_page = 8'h00;
    logic [7:0]  mon_idx  = 8'h00;
    logic [7:0]  exp_byte = 8'h00;
    logic [15:0] last_rd  = 16'h0000;
    int rd_cnt = 0, wr_cnt = 0, seq_err = 0, par_err = 0, stall = 0, last_stall = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (!bus.ready) stall++;
            else begin
                if (stall != 0) last_stall = stall;
                stall   = 0;
                mon_idx = 8'h00;
            end
            if (bus.dma_active && !bus.dma_write) begin
                rd_cnt++;
                last_rd = bus.dma_addr;
                if (bus.dma_addr !== {exp_page, mon_idx}) seq_err++;
                if (tb_par !== 1'b0) par_err++;
                exp_byte = memf(bus.dma_addr);
            end else if (bus.dma_write) begin
                wr_cnt++;
                if (!bus.dma_active || bus.dma_addr !== OAM_DATA_ADDR || bus.dma_d_out !== exp_byte)
                    seq_err++;
                mon_idx++;
            end else if (bus.dma_addr !== 16'h0000 || bus.dma_d_out !== 8'h00) begin
                seq_err++;
            end
            if (bus.ready && bus.dma_active) seq_err++;
        end
    end

    int rd0, wr0, se0, pe0;

    task automatic snap();
        rd0 = rd_cnt; wr0 = wr_cnt; se0 = seq_err; pe0 = par_err;
    endtask

    // Issue a $4014 write in a cycle whose parity is want_par.
    task automatic trig(input logic [7:0] pg, input logic want_par);
        @(posedge clk); #1;
        if (tb_par !== want_par) begin @(posedge clk); #1; end
        bus.cpu_write = 1'b1; bus.cpu_addr = DMA_REG_ADDR; bus.cpu_d_out = pg;
        @(posedge clk); #1;
        bus.cpu_write = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_d_out = 8'h00;
        chk("latency_ready", bus.ready, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!bus.ready && n < 700) begin @(negedge clk); n++; end
        #1;
        chk({tag, "_timeout"}, (n < 700), 1'b1);
    endtask

    task automatic xfer_checks(input string tag, input logic [15:0] last, input int stall_exp);
        chk({tag, "_reads"},  rd_cnt - rd0, 256);
        chk({tag, "_writes"}, wr_cnt - wr0, 256);
        chk({tag, "_seq"},    seq_err - se0, 0);
        chk({tag, "_parity"}, par_err - pe0, 0);
        chk({tag, "_last_rd"}, last_rd, last);
        chk({tag, "_stall"},  last_stall, stall_exp);
        chk({tag, "_ready"},  bus.ready, 1'b1);
    endtask

    initial begin
        int n;
        int hi;
        logic [15:0] near [3];
        near[0] = 16'hC014; near[1] = 16'h4015; near[2] = 16'h0014;

        // Reset held with a coincident trigger: reset wins.
        reset = 1'b0;
        bus.cpu_write = 1'b1; bus.cpu_addr = DMA_REG_ADDR; bus.cpu_d_out = 8'h02;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_active", bus.dma_active, 1'b0);
        chk("rst_addr", bus.dma_addr, 16'h0000);
        chk("rst_write", bus.dma_write, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_d_out = 8'h00;
        hi = 0;
        repeat (4) begin @(negedge clk); if (bus.ready && !bus.dma_active) hi++; end
        chk("rst_no_xfer", hi, 4);

        // Full 16-bit decode: near-miss addresses do not trigger.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.cpu_write = 1'b1; bus.cpu_addr = near[i]; bus.cpu_d_out = 8'h02;
            @(posedge clk); #1;
            bus.cpu_write = 1'b0; bus.cpu_addr = 16'h0000;
            @(negedge clk);
            chk($sformatf("decode_%0h", near[i]), bus.ready, 1'b1);
        end

        // Basic copy, trigger on an even cycle -> odd HALT, no ALIGN.
        exp_page = 8'h02; snap();
        trig(8'h02, 1'b0);
        wait_idle("basic");
        xfer_checks("basic", 16'h02FF, 513);

        // Trigger on an odd cycle -> even HALT, one ALIGN cycle.
        exp_page = 8'h02; snap();
        trig(8'h02, 1'b1);
        wait_idle("align");
        xfer_checks("align", 16'h02FF, 514);

        // Retrigger mid-transfer with a different page is ignored.
        exp_page = 8'h02; snap();
        trig(8'h02, 1'b0);
        n = 0;
        while (!(bus.dma_active && !bus.dma_write && mon_idx == 8'h40) && n < 700) begin
            @(negedge clk); #1; n++;
        end
        chk("retrig_reach", (n < 700), 1'b1);
        bus.cpu_write = 1'b1; bus.cpu_addr = DMA_REG_ADDR; bus.cpu_d_out = 8'h07;
        repeat (2) @(posedge clk);
        #1; bus.cpu_write = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_d_out = 8'h00;
        wait_idle("retrig");
        xfer_checks("retrig", 16'h02FF, 513);

        // Reset during the WRITE of idx 0x80, then a clean copy from page 03.
        exp_page = 8'h02;
        trig(8'h02, 1'b1);
        n = 0;
        while (!(bus.dma_write && mon_idx == 8'h81) && n < 700) begin
            @(negedge clk); #1; n++;
        end
        chk("midrst_reach", (n < 700), 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready", bus.ready, 1'b1);
        chk("midrst_active", bus.dma_active, 1'b0);
        chk("midrst_write", bus.dma_write, 1'b0);
        reset = 1'b1;
        exp_page = 8'h03; snap();
        trig(8'h03, 1'b0);
        wait_idle("after_rst");
        xfer_checks("after_rst", 16'h03FF, 513);

        // Top page: ends at $FFFF with no wrap to $0000.
        exp_page = 8'hFF; snap();
        trig(8'hFF, 1'b1);
        wait_idle("pageff");
        xfer_checks("pageff", 16'hFFFF, 514);
        repeat (3) @(negedge clk);
        chk("pageff_quiet", rd_cnt - rd0, 256);

        // PPU register page is read as ordinary source addresses.
        exp_page = 8'h20; snap();
        trig(8'h20, 1'b0);
        wait_idle("page20");
        xfer_checks("page20", 16'h20FF, 513);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
